uc_seq: RTL and testbench

Sequential control unit for the microc datapath. It decodes the 6-bit `Opcode` and the registered `z` flag and drives `s_inc`, `s_inm`, `we3`, `wez` and `Op` each cycle, adding a PC load enable for the datapath revision that has one. It replaces the hand-driven control sequences with an FSM that provides a post-reset idle cycle, debug single-stepping, HALT and illegal-opcode trap states, and a retired-instruction counter.

---
 rtl/uc_pkg.sv | 48 ++++
 rtl/uc_decode.sv | 49 ++++
 rtl/uc_seq.sv | 97 +++++++++
 tb/tb_uc_seq.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared definitions for the microc sequential control unit: opcode patterns,
// ALU operation codes, control-word layout and FSM state encoding.
package uc_pkg;

    // Opcode patterns and the masks selecting their fixed bits
    localparam logic [5:0] OPC_NOP   = 6'b000000;
    localparam logic [5:0] OPC_LI    = 6'b000100;
    localparam logic [5:0] OPC_ALU   = 6'b001000;
    localparam logic [5:0] OPC_J     = 6'b010000;
    localparam logic [5:0] OPC_JZ    = 6'b010001;
    localparam logic [5:0] OPC_JNZ   = 6'b010010;
    localparam logic [5:0] OPC_HALT  = 6'b111111;

    localparam logic [5:0] MASK_FULL = 6'b111111;
    localparam logic [5:0] MASK_LI   = 6'b111100;
    localparam logic [5:0] MASK_ALU  = 6'b111000;

    // ALU operation driven when the ALU is not in use
    localparam logic [2:0] ALU_OP_NONE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP_WAIT = 3'd2,
        ST_STEP_EXEC = 3'd3,
        ST_HALT      = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
        logic       pc_we;
    } ctrl_t;

    localparam ctrl_t CTRL_OFF = '{s_inc: 1'b0, s_inm: 1'b0, we3: 1'b0, wez: 1'b0,
                                   op: ALU_OP_NONE, pc_we: 1'b0};

    function automatic logic opc_match(input logic [5:0] opcode,
                                       input logic [5:0] pattern,
                                       input logic [5:0] mask);
        return (opcode & mask) == pattern;
    endfunction

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode + zero-flag decoder producing the datapath control word,
// a legal-opcode flag and a HALT flag.
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output ctrl_t      ctrl,
    output logic       legal,
    output logic       is_halt
);

    always_comb begin
        // NOTE: every output gets a default before the decode so no path leaves
        // a value unassigned, which would infer a latch.
        ctrl    = CTRL_OFF;
        legal   = 1'b1;
        is_halt = 1'b0;

        if (opc_match(opcode, OPC_NOP, MASK_FULL)) begin
            ctrl.s_inc = 1'b1;
            ctrl.pc_we = 1'b1;
        end else if (opc_match(opcode, OPC_LI, MASK_LI)) begin
            ctrl.s_inc = 1'b1;
            ctrl.s_inm = 1'b1;
            ctrl.we3   = 1'b1;
            ctrl.pc_we = 1'b1;
        end else if (opc_match(opcode, OPC_ALU, MASK_ALU)) begin
            ctrl.s_inc = 1'b1;
            ctrl.we3   = 1'b1;
            ctrl.wez   = 1'b1;
            ctrl.op    = opcode[2:0];
            ctrl.pc_we = 1'b1;
        end else if (opc_match(opcode, OPC_J, MASK_FULL)) begin
            ctrl.pc_we = 1'b1;
        end else if (opc_match(opcode, OPC_JZ, MASK_FULL)) begin
            ctrl.s_inc = ~z;
            ctrl.pc_we = 1'b1;
        end else if (opc_match(opcode, OPC_JNZ, MASK_FULL)) begin
            ctrl.s_inc = z;
            ctrl.pc_we = 1'b1;
        end else if (opc_match(opcode, OPC_HALT, MASK_FULL)) begin
            is_halt = 1'b1;
        end else begin
            legal = 1'b0;
        end
    end

endmodule

// File: rtl/uc_seq.sv
// Sequential control unit: run/single-step FSM with HALT and TRAP states,
// step edge detection, control output gating and a retired-instruction counter.
module uc_seq
    import uc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic        z,
    input  logic        run_mode,
    input  logic        step_req,
    output logic        s_inc,
    output logic        s_inm,
    output logic        we3,
    output logic        wez,
    output logic [2:0]  Op,
    output logic        pc_we,
    output logic        step_ack,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] retired
);

    state_t      state_q, state_d;
    logic        step_req_q;
    logic [15:0] retired_q;

    ctrl_t dec_ctrl, ctrl_out;
    logic  dec_legal, dec_halt;
    logic  in_exec, step_edge, retire;

    uc_decode u_decode (
        .opcode  (Opcode),
        .z       (z),
        .ctrl    (dec_ctrl),
        .legal   (dec_legal),
        .is_halt (dec_halt)
    );

    assign in_exec   = (state_q == ST_RUN) || (state_q == ST_STEP_EXEC);
    assign step_edge = step_req & ~step_req_q;
    assign retire    = in_exec & dec_legal & ~dec_halt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      state_d = run_mode ? ST_RUN : ST_STEP_WAIT;
            ST_RUN: begin
                if (dec_halt)       state_d = ST_HALT;
                else if (!dec_legal) state_d = ST_TRAP;
                else if (!run_mode) state_d = ST_STEP_WAIT;
            end
            // run_mode wins over a coincident step edge; that edge is dropped
            ST_STEP_WAIT: begin
                if (run_mode)       state_d = ST_RUN;
                else if (step_edge) state_d = ST_STEP_EXEC;
            end
            ST_STEP_EXEC: begin
                if (dec_halt)        state_d = ST_HALT;
                else if (!dec_legal) state_d = ST_TRAP;
                else                 state_d = ST_STEP_WAIT;
            end
            ST_HALT:      state_d = ST_HALT;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            step_req_q <= 1'b0;
            retired_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            step_req_q <= step_req;
            if (retire) retired_q <= retired_q + 16'd1;
        end
    end

    // Enables depend on registered state, so reset forces them low at once
    assign ctrl_out = in_exec ? dec_ctrl : CTRL_OFF;

    assign s_inc    = ctrl_out.s_inc;
    assign s_inm    = ctrl_out.s_inm;
    assign we3      = ctrl_out.we3;
    assign wez      = ctrl_out.wez;
    assign Op       = ctrl_out.op;
    assign pc_we    = ctrl_out.pc_we;
    assign step_ack = (state_q == ST_STEP_EXEC);
    assign halted   = (state_q == ST_HALT);
    assign illegal  = (state_q == ST_TRAP);
    assign retired  = retired_q;

endmodule

// File: tb/tb_uc_seq.sv
// Directed self-checking bench for uc_seq: decode words, stepping, HALT/TRAP,
// reset behaviour and retired-counter wrap.
module tb_uc_seq;

    logic        clk = 1'b1;
    logic        reset;
    logic [5:0]  Opcode;
    logic        z;
    logic        run_mode;
    logic        step_req;
    logic        s_inc, s_inm, we3, wez, pc_we;
    logic [2:0]  Op;
    logic        step_ack, halted, illegal;
    logic [15:0] retired;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_ret;

    wire [7:0] ctl  = {s_inc, s_inm, we3, wez, Op, pc_we};
    wire [2:0] stat = {halted, illegal, step_ack};

    localparam logic [7:0] W_OFF  = 8'h00;
    localparam logic [7:0] W_NOP  = 8'h81;
    localparam logic [7:0] W_LI   = 8'hE1;
    localparam logic [7:0] W_JMP  = 8'h01;

    uc_seq dut (
        .clk      (clk),
        .reset    (reset),
        .Opcode   (Opcode),
        .z        (z),
        .run_mode (run_mode),
        .step_req (step_req),
        .s_inc    (s_inc),
        .s_inm    (s_inm),
        .we3      (we3),
        .wez      (wez),
        .Op       (Op),
        .pc_we    (pc_we),
        .step_ack (step_ack),
        .halted   (halted),
        .illegal  (illegal),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; the DUT samples on the rising edge.
    task automatic next_cycle(input bit executed);
        @(negedge clk);
        if (executed) exp_ret = exp_ret + 16'd1;
    endtask

    task automatic reset_release(input logic rm, input logic [5:0] opc);
        reset = 1'b0; run_mode = rm; Opcode = opc; z = 1'b0; step_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_ret = 16'h0000;
    endtask

    task automatic test_reset;
        reset = 1'b0; run_mode = 1'b1; Opcode = 6'b000100; z = 1'b0; step_req = 1'b0;
        exp_ret = 16'h0000;
        #1;
        checks++;
        if (ctl !== W_OFF || stat !== 3'b000 || retired !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state: ctl=%h stat=%b retired=%h expected ctl=00 stat=000 retired=0000", ctl, stat, retired);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (ctl !== W_OFF) begin
            failures++;
            $display("FAIL idle_cycle: ctl=%h expected %h", ctl, W_OFF);
        end
        next_cycle(1'b0);
        #1;
        checks++;
        if (ctl !== W_LI || retired !== 16'h0000) begin
            failures++;
            $display("FAIL first_li: ctl=%h retired=%h expected ctl=%h retired=0000", ctl, retired, W_LI);
        end
        next_cycle(1'b1);
        #1;
        checks++;
        if (retired !== 16'h0001) begin
            failures++;
            $display("FAIL li_retired: retired=%h expected 0001", retired);
        end
    endtask

    task automatic test_alu;
        logic [15:0] start;
        start = retired;
        Opcode = 6'b001010;
        #1;
        checks++;
        if (ctl !== 8'hB5) begin
            failures++;
            $display("FAIL alu_010: ctl=%h expected b5", ctl);
        end
        next_cycle(1'b1);
        Opcode = 6'b001011;
        #1;
        checks++;
        if (ctl !== 8'hB7) begin
            failures++;
            $display("FAIL alu_011: ctl=%h expected b7", ctl);
        end
        next_cycle(1'b1);
        Opcode = 6'b000000;
        #1;
        checks++;
        if (retired !== start + 16'd2) begin
            failures++;
            $display("FAIL alu_retired: retired=%h expected %h", retired, start + 16'd2);
        end
    endtask

    task automatic test_jumps;
        logic [5:0] opcs [5] = '{6'b010001, 6'b010001, 6'b010010, 6'b010010, 6'b010000};
        logic       zs   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] exps [5] = '{W_JMP, W_NOP, W_NOP, W_JMP, W_JMP};
        next_cycle(1'b1);
        for (int i = 0; i < 5; i++) begin
            Opcode = opcs[i]; z = zs[i];
            #1;
            checks++;
            if (ctl !== exps[i]) begin
                failures++;
                $display("FAIL jump_%0d: opcode=%b z=%b ctl=%h expected %h", i, opcs[i], zs[i], ctl, exps[i]);
            end
            next_cycle(1'b1);
        end
        Opcode = 6'b000000; z = 1'b0;
        #1;
        checks++;
        if (ctl !== W_NOP || retired !== exp_ret) begin
            failures++;
            $display("FAIL nop_retired: ctl=%h retired=%h expected ctl=%h retired=%h", ctl, retired, W_NOP, exp_ret);
        end
    endtask

    task automatic test_single_step;
        int acks;
        run_mode = 1'b0;
        next_cycle(1'b1);
        #1;
        checks++;
        if (ctl !== W_OFF || step_ack !== 1'b0) begin
            failures++;
            $display("FAIL step_wait_idle: ctl=%h ack=%b expected ctl=00 ack=0", ctl, step_ack);
        end
        step_req = 1'b1;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (step_ack === 1'b1) acks++;
            @(negedge clk);
        end
        exp_ret = exp_ret + 16'd1;
        #1;
        checks++;
        if (acks !== 1 || retired !== exp_ret) begin
            failures++;
            $display("FAIL held_step: acks=%0d retired=%h expected acks=1 retired=%h", acks, retired, exp_ret);
        end
        step_req = 1'b0;
        @(negedge clk);
        step_req = 1'b1;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (step_ack === 1'b1) acks++;
            @(negedge clk);
        end
        exp_ret = exp_ret + 16'd1;
        #1;
        checks++;
        if (acks !== 1 || retired !== exp_ret) begin
            failures++;
            $display("FAIL second_step: acks=%0d retired=%h expected acks=1 retired=%h", acks, retired, exp_ret);
        end
    endtask

    task automatic test_run_priority;
        step_req = 1'b0;
        @(negedge clk);
        step_req = 1'b1;
        run_mode = 1'b1;
        #1;
        checks++;
        if (ctl !== W_OFF || step_ack !== 1'b0) begin
            failures++;
            $display("FAIL prio_wait: ctl=%h ack=%b expected ctl=00 ack=0", ctl, step_ack);
        end
        next_cycle(1'b0);
        #1;
        checks++;
        if (ctl !== W_NOP || step_ack !== 1'b0) begin
            failures++;
            $display("FAIL prio_run: ctl=%h ack=%b expected ctl=%h ack=0", ctl, step_ack, W_NOP);
        end
        next_cycle(1'b1);
        step_req = 1'b0;
        #1;
        checks++;
        if (retired !== exp_ret) begin
            failures++;
            $display("FAIL prio_retired: retired=%h expected %h", retired, exp_ret);
        end
    endtask

    task automatic test_halt;
        int bad;
        Opcode = 6'b111111;
        #1;
        checks++;
        if (ctl !== W_OFF || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_decode: ctl=%h halted=%b expected ctl=00 halted=0", ctl, halted);
        end
        next_cycle(1'b0);
        Opcode = 6'b000100;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (halted !== 1'b1 || ctl !== W_OFF || retired !== exp_ret) begin
                failures++;
                $display("FAIL halt_hold_%0d: halted=%b ctl=%h retired=%h expected halted=1 ctl=00 retired=%h", i, halted, ctl, retired, exp_ret);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || retired !== 16'h0000 || ctl !== W_OFF) begin
            failures++;
            $display("FAIL halt_reset: halted=%b retired=%h ctl=%h expected 0 0000 00", halted, retired, ctl);
        end
    endtask

    task automatic test_reset_mid;
        reset_release(1'b1, 6'b000100);
        next_cycle(1'b0);
        #1;
        checks++;
        if (ctl !== W_LI) begin
            failures++;
            $display("FAIL mid_pre: ctl=%h expected %h", ctl, W_LI);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ctl !== W_OFF || retired !== 16'h0000) begin
            failures++;
            $display("FAIL mid_reset: ctl=%h retired=%h expected ctl=00 retired=0000", ctl, retired);
        end
    endtask

    task automatic test_illegal;
        reset_release(1'b1, 6'b100000);
        next_cycle(1'b0);
        #1;
        checks++;
        if (ctl !== W_OFF || illegal !== 1'b0) begin
            failures++;
            $display("FAIL illegal_decode: ctl=%h illegal=%b expected ctl=00 illegal=0", ctl, illegal);
        end
        next_cycle(1'b0);
        #1;
        checks++;
        if (illegal !== 1'b1 || halted !== 1'b0 || ctl !== W_OFF || retired !== 16'h0000) begin
            failures++;
            $display("FAIL illegal_trap: illegal=%b halted=%b ctl=%h retired=%h expected 1 0 00 0000", illegal, halted, ctl, retired);
        end
    endtask

    task automatic test_wrap;
        reset_release(1'b1, 6'b000000);
        next_cycle(1'b0);
        repeat (65535) @(negedge clk);
        #1;
        checks++;
        if (retired !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_max: retired=%h expected ffff", retired);
        end
        @(negedge clk);
        #1;
        checks++;
        if (retired !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_zero: retired=%h expected 0000", retired);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_jumps();
        test_single_step();
        test_run_priority();
        test_halt();
        test_reset_mid();
        test_illegal();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
